tdm_mux_scan: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer with a valid/ready output stage.

---
 rtl/tdm_mux_pkg.sv | 16 +
 rtl/tdm_mux_scan_if.sv | 33 +++
 rtl/rr_next_ch.sv | 43 ++++
 rtl/tdm_mux_scan.sv | 167 ++++++++++++++++
 tb/tb_tdm_mux_scan.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared types and constants for the TDM scan multiplexer.
//   state_e     : controller state (idle / manual select / time-division scan)
//   MODE_MANUAL : mode input value that selects manual forwarding
//   MODE_SCAN   : mode input value that selects scanning
package tdm_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/tdm_mux_scan_if.sv
// Control, channel data and valid/ready output bundle of the TDM scan multiplexer.
//   en, mode, sel, ch_mask, din : control and channel inputs (driven by master)
//   dout, dout_ch, dout_valid   : registered sample, its channel, and its valid flag
//   dout_ready                  : downstream accept (driven by master)
//   wrap                        : one-cycle pulse when the scan pointer wraps
interface tdm_mux_scan_if #(
   parameter int unsigned N_CH = 8,
   parameter int unsigned W    = 8
);
   localparam int unsigned CW = $clog2(N_CH);

   logic              en;
   logic              mode;
   logic [CW-1:0]     sel;
   logic [N_CH-1:0]   ch_mask;
   logic [N_CH*W-1:0] din;
   logic [W-1:0]      dout;
   logic [CW-1:0]     dout_ch;
   logic              dout_valid;
   logic              dout_ready;
   logic              wrap;

   modport master (
      output en, mode, sel, ch_mask, din, dout_ready,
      input  dout, dout_ch, dout_valid, wrap
   );

   modport slave (
      input  en, mode, sel, ch_mask, din, dout_ready,
      output dout, dout_ch, dout_valid, wrap
   );

endinterface

// File: rtl/rr_next_ch.sv
// Combinational next-enabled-channel finder.
//   mask   : per-channel enable
//   p      : current position
//   nxt_c  : lowest enabled index above p, else lowest enabled index overall
//   wrap_c : nxt_c <= p (search wrapped; includes a single enabled channel)
//   any_c  : at least one channel enabled
module rr_next_ch
   import tdm_mux_pkg::*;
#(
   parameter  int unsigned N_CH = 8,
   localparam int unsigned CW   = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] mask,
   input  logic [CW-1:0]   p,
   output logic [CW-1:0]   nxt_c,
   output logic            wrap_c,
   output logic            any_c
);

   logic [CW-1:0] hi;
   logic [CW-1:0] lo;
   logic          hi_found;

   // Descending scan: the last hit written is the lowest qualifying index.
   always_comb begin
      hi       = '0;
      lo       = '0;
      hi_found = 1'b0;
      for (int j = int'(N_CH) - 1; j >= 0; j--) begin
         if (mask[j]) begin
            lo = CW'(j);
            if (CW'(j) > p) begin
               hi       = CW'(j);
               hi_found = 1'b1;
            end
         end
      end
      any_c  = |mask;
      nxt_c  = hi_found ? hi : lo;
      wrap_c = any_c && !hi_found;
   end

endmodule

// File: rtl/tdm_mux_scan.sv
// N-channel registered multiplexer with manual select or TDM scan, valid/ready output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tdm_mux_scan_if slave (control inputs, channel data, output stage)
module tdm_mux_scan
   import tdm_mux_pkg::*;
#(
   parameter int unsigned N_CH  = 8,
   parameter int unsigned W     = 8,
   parameter int unsigned DWELL = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   tdm_mux_scan_if.slave  bus
);

   localparam int unsigned CW  = $clog2(N_CH);
   localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

   state_e         state_q, state_d;
   logic [CW-1:0]  ptr_q, ptr_d;
   logic [DCW-1:0] dwell_q, dwell_d;
   logic [W-1:0]   dout_q, dout_d;
   logic [CW-1:0]  dout_ch_q, dout_ch_d;
   logic           valid_q, valid_d;
   logic           wrap_q, wrap_d;

   logic [W-1:0]   sel_data_c, ptr_data_c;
   logic           sel_hit_c, ptr_en_c, slot_free_c;
   logic [CW-1:0]  nxt_ptr_c, entry_ptr_c;
   logic           nxt_wrap_c, mask_any_c;
   logic           entry_wrap_unused_c, entry_any_unused_c;

   // next(ptr) for scan advance
   rr_next_ch #(.N_CH(N_CH)) u_next (
      .mask   (bus.ch_mask),
      .p      (ptr_q),
      .nxt_c  (nxt_ptr_c),
      .wrap_c (nxt_wrap_c),
      .any_c  (mask_any_c)
   );

   // Searching from the top index always wraps, yielding the lowest enabled channel.
   rr_next_ch #(.N_CH(N_CH)) u_entry (
      .mask   (bus.ch_mask),
      .p      (CW'(N_CH - 1)),
      .nxt_c  (entry_ptr_c),
      .wrap_c (entry_wrap_unused_c),
      .any_c  (entry_any_unused_c)
   );

   assign slot_free_c = !valid_q || bus.dout_ready;

   // Channel data for sel and ptr; indices >= N_CH select nothing.
   always_comb begin
      sel_data_c = '0;
      sel_hit_c  = 1'b0;
      ptr_data_c = '0;
      ptr_en_c   = 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
         if (bus.sel == CW'(k)) begin
            sel_data_c = bus.din[k*W +: W];
            sel_hit_c  = 1'b1;
         end
         if (ptr_q == CW'(k)) begin
            ptr_data_c = bus.din[k*W +: W];
            ptr_en_c   = bus.ch_mask[k];
         end
      end
   end

   // Next state, pointer/dwell update and output load.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      dwell_d   = dwell_q;
      dout_d    = dout_q;
      dout_ch_d = dout_ch_q;
      valid_d   = valid_q;
      wrap_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (slot_free_c) valid_d = 1'b0;
            if (bus.en) begin
               if (bus.mode == MODE_SCAN) begin
                  state_d = ST_SCAN;
                  ptr_d   = entry_ptr_c;
                  dwell_d = '0;
               end else begin
                  state_d = ST_MANUAL;
               end
            end
         end
         ST_MANUAL: begin
            if (slot_free_c) begin
               if (sel_hit_c) begin
                  dout_d    = sel_data_c;
                  dout_ch_d = bus.sel;
                  valid_d   = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
            if (!bus.en) begin
               state_d = ST_IDLE;
            end else if (bus.mode == MODE_SCAN) begin
               state_d = ST_SCAN;
               ptr_d   = entry_ptr_c;
               dwell_d = '0;
            end
         end
         ST_SCAN: begin
            if (slot_free_c) begin
               if (!mask_any_c) begin
                  valid_d = 1'b0;
               end else if (ptr_en_c) begin
                  dout_d    = ptr_data_c;
                  dout_ch_d = ptr_q;
                  valid_d   = 1'b1;
                  if (dwell_q == DCW'(DWELL - 1)) begin
                     ptr_d   = nxt_ptr_c;
                     dwell_d = '0;
                     wrap_d  = nxt_wrap_c;
                  end else begin
                     dwell_d = dwell_q + DCW'(1);
                  end
               end else begin
                  // Current channel was masked off: skip it without a sample.
                  valid_d = 1'b0;
                  ptr_d   = nxt_ptr_c;
                  dwell_d = '0;
                  wrap_d  = nxt_wrap_c;
               end
            end
            if (!bus.en) state_d = ST_IDLE;
            else if (bus.mode == MODE_MANUAL) state_d = ST_MANUAL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         dwell_q   <= '0;
         dout_q    <= '0;
         dout_ch_q <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         dwell_q   <= dwell_d;
         dout_q    <= dout_d;
         dout_ch_q <= dout_ch_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_ch    = dout_ch_q;
   assign bus.dout_valid = valid_q;
   assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_tdm_mux_scan.sv
// Directed bench for tdm_mux_scan: three instances (8ch DWELL=1, 8ch DWELL=3, 10ch).
module tb_tdm_mux_scan;

   logic clk = 1'b0;
   logic rst_n;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   tdm_mux_scan_if #(.N_CH(8),  .W(8)) b8  ();
   tdm_mux_scan_if #(.N_CH(8),  .W(8)) b8d ();
   tdm_mux_scan_if #(.N_CH(10), .W(8)) b10 ();

   tdm_mux_scan #(.N_CH(8),  .W(8), .DWELL(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   tdm_mux_scan #(.N_CH(8),  .W(8), .DWELL(3)) u8d (.clk(clk), .rst_n(rst_n), .bus(b8d));
   tdm_mux_scan #(.N_CH(10), .W(8), .DWELL(1)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag,
                          input logic [7:0] d, input logic [3:0] ch, input logic v, input logic w,
                          input logic [7:0] ed, input logic [3:0] ech, input logic ev, input logic ew);
      chk({tag, ".dout"},  32'(d),  32'(ed));
      chk({tag, ".ch"},    32'(ch), 32'(ech));
      chk({tag, ".valid"}, 32'(v),  32'(ev));
      chk({tag, ".wrap"},  32'(w),  32'(ew));
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   int seq2[6]  = '{0, 2, 5, 7, 0, 2};
   int seq3[7]  = '{0, 0, 0, 1, 1, 1, 0};
   int seq4[3]  = '{5, 7, 0};

   initial begin
      rst_n = 1'b0;
      b8.en = 1'b0;  b8.mode = 1'b0;  b8.sel = '0;  b8.ch_mask = '0;  b8.dout_ready = 1'b1;
      b8d.en = 1'b0; b8d.mode = 1'b0; b8d.sel = '0; b8d.ch_mask = '0; b8d.dout_ready = 1'b1;
      b10.en = 1'b0; b10.mode = 1'b0; b10.sel = '0; b10.ch_mask = '0; b10.dout_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         b8.din[k*8 +: 8]  = 8'(8'h10 + k);
         b8d.din[k*8 +: 8] = 8'(8'h10 + k);
      end
      for (int k = 0; k < 10; k++) b10.din[k*8 +: 8] = 8'(8'h10 + k);

      // Reset state
      step; step;
      chk_out("rst8",  b8.dout,  4'(b8.dout_ch),  b8.dout_valid,  b8.wrap,  8'h00, 4'd0, 1'b0, 1'b0);
      chk_out("rst10", b10.dout, b10.dout_ch,     b10.dout_valid, b10.wrap, 8'h00, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step;

      // 1: manual select, one-edge latency once in MANUAL
      b8.en = 1'b1; b8.mode = 1'b0; b8.sel = 3'd5;
      step;
      chk("idle_noload.valid", 32'(b8.dout_valid), 32'd0);
      step;
      chk_out("man5", b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap, 8'h15, 4'd5, 1'b1, 1'b0);
      b8.sel = 3'd2;
      step;
      chk_out("man2", b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap, 8'h12, 4'd2, 1'b1, 1'b0);

      // 2: switch to scan; the switching edge still loads the manual channel
      b8.mode = 1'b1; b8.ch_mask = 8'b1010_0101;
      step;
      chk_out("switch", b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap, 8'h12, 4'd2, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step;
         chk_out($sformatf("scan%0d", i), b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap,
                 8'(8'h10 + seq2[i]), 4'(seq2[i]), 1'b1, (seq2[i] == 7) ? 1'b1 : 1'b0);
      end

      // 4: back-pressure holds everything, then resumes at ch5
      b8.dout_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step;
         chk_out($sformatf("stall%0d", i), b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap,
                 8'h12, 4'd2, 1'b1, 1'b0);
      end
      b8.dout_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         chk_out($sformatf("resume%0d", i), b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap,
                 8'(8'h10 + seq4[i]), 4'(seq4[i]), 1'b1, (seq4[i] == 7) ? 1'b1 : 1'b0);
      end

      // 5: empty mask drops valid only after acceptance; then single channel 6
      b8.dout_ready = 1'b0; b8.ch_mask = 8'h00;
      step;
      chk("mask0_hold.valid", 32'(b8.dout_valid), 32'd1);
      chk("mask0_hold.ch",    32'(b8.dout_ch),    32'd0);
      b8.dout_ready = 1'b1;
      step;
      chk("mask0_drop.valid", 32'(b8.dout_valid), 32'd0);
      step;
      chk("mask0_stay.valid", 32'(b8.dout_valid), 32'd0);
      b8.ch_mask = 8'h40;
      step;
      chk("mask40_skip.valid", 32'(b8.dout_valid), 32'd0);
      chk("mask40_skip.wrap",  32'(b8.wrap),       32'd0);
      step;
      chk_out("ch6a", b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap, 8'h16, 4'd6, 1'b1, 1'b1);
      step;
      chk_out("ch6b", b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap, 8'h16, 4'd6, 1'b1, 1'b1);

      // Leaving scan with a pending sample keeps it until accepted
      b8.en = 1'b0; b8.dout_ready = 1'b0;
      step;
      chk_out("leave", b8.dout, 4'(b8.dout_ch), b8.dout_valid, b8.wrap, 8'h16, 4'd6, 1'b1, 1'b0);
      step;
      chk("idle_hold.valid", 32'(b8.dout_valid), 32'd1);
      b8.dout_ready = 1'b1;
      step;
      chk("idle_accept.valid", 32'(b8.dout_valid), 32'd0);

      // 3: DWELL=3 scan over channels 0 and 1
      b8d.en = 1'b1; b8d.mode = 1'b1; b8d.ch_mask = 8'h03;
      step;
      chk("dwell_entry.valid", 32'(b8d.dout_valid), 32'd0);
      for (int i = 0; i < 7; i++) begin
         step;
         chk_out($sformatf("dwell%0d", i), b8d.dout, 4'(b8d.dout_ch), b8d.dout_valid, b8d.wrap,
                 8'(8'h10 + seq3[i]), 4'(seq3[i]), 1'b1, (i == 5) ? 1'b1 : 1'b0);
      end

      // 6: N_CH=10, top legal select, out-of-range select, async reset mid-stall
      b10.en = 1'b1; b10.mode = 1'b0; b10.sel = 4'd9;
      step; step;
      chk_out("sel9", b10.dout, b10.dout_ch, b10.dout_valid, b10.wrap, 8'h19, 4'd9, 1'b1, 1'b0);
      b10.sel = 4'd12;
      step;
      chk("sel12.valid", 32'(b10.dout_valid), 32'd0);
      b10.sel = 4'd3;
      step;
      chk_out("sel3", b10.dout, b10.dout_ch, b10.dout_valid, b10.wrap, 8'h13, 4'd3, 1'b1, 1'b0);
      b10.dout_ready = 1'b0;
      step;
      chk_out("stall10", b10.dout, b10.dout_ch, b10.dout_valid, b10.wrap, 8'h13, 4'd3, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_out("arst10", b10.dout, b10.dout_ch, b10.dout_valid, b10.wrap, 8'h00, 4'd0, 1'b0, 1'b0);
      chk_out("arst8d", b8d.dout, 4'(b8d.dout_ch), b8d.dout_valid, b8d.wrap, 8'h00, 4'd0, 1'b0, 1'b0);
      step;
      rst_n = 1'b1;
      step;
      chk("post_rst.valid", 32'(b10.dout_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
